register_file: RTL and testbench
================================

# register_file

General-purpose 32-entry × 32-bit register file with one synchronous write port and two independently enabled, registered read ports (A and B). Sits in the datapath between instruction decode and the ALU. Each clock edge supplies two operand reads and accepts one result write-back.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of In/OutA/OutB
- ADDR_WIDTH, 5, address width
- DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- In  input  DATA_WIDTH  write data
- address_w  input  ADDR_WIDTH  write address
- enable_w  input  1  write enable, active-high
- address_a  input  ADDR_WIDTH  read port A address
- enable_a  input  1  read port A enable, active-high
- address_b  input  ADDR_WIDTH  read port B address
- enable_b  input  1  read port B enable, active-high
- OutA  output  DATA_WIDTH  registered read data, port A
- OutB  output  DATA_WIDTH  registered read data, port B

## Operation
- Storage is DEPTH registers of DATA_WIDTH bits. All entries, including entry 0, are ordinary writable registers. There is no hardwired zero.
- Write: on a rising clk edge with enable_w=1, mem[address_w] <= In. With enable_w=0 the array is unchanged.
- Read A: on a rising clk edge with enable_a=1, OutA <= mem[address_a]. With enable_a=0, OutA holds its previous value.
- Read B: identical to read A, using address_b, enable_b and OutB. The ports are fully independent.
- Both read ports may address the same entry in the same cycle. Both return the same data.
- Read/write collision, same address in the same cycle: the result is governed by the Configuration section.
- Addresses are full-range. Every value 0..DEPTH-1 is valid, so there is no out-of-range case.
- Reset (rst=1): immediately, without waiting for clk, clears every mem entry, OutA and OutB to 0. While rst=1, writes and reads are ignored.
- Reset asserted mid-operation: any in-flight write is discarded and all state reads 0.

## Timing
- Write latency: data written at edge N is visible to a read sampled at edge N+1 and appears on OutX after edge N+1.
- Read latency: 1 cycle. The address and enable sampled at edge N produce OutX valid after edge N, stable until the next enabled edge.
- No combinational path from any input to OutA/OutB.
- Reset values: OutA=0, OutB=0, all mem=0.
- Release of rst is synchronous to clk. The first operation takes effect at the first rising edge after rst falls.

## Configuration
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: write-to-read forwarding. If enable_w=1, enable_x=1 and address_x==address_w at the same edge, OutX <= In, the new data. Applies independently to both ports.
- Undefined: no forwarding. In the same case OutX <= the old contents of mem[address_x], and the new value is visible from the next edge.
- Default build leaves the macro undefined.

## Test plan
- Reset: write 0xDEADBEEF to reg 5, then pulse rst asynchronously between edges -> OutA/OutB go to 0 immediately, and a subsequent read of reg 5 returns 0.
- Fill and read back: for i=0..31 write In=2*i to reg i, then read A sweeping addresses 0..31 -> OutA = 2*i one cycle after each address. Then sweep port B the same way -> OutB = 2*i.
- Dual random read: after the fill, drive address_a from 0..15 and address_b from 16..31 every cycle -> OutA=2*address_a and OutB=2*address_b, each with 1-cycle latency.
- Enable hold: read reg 7 (0x0E) on A, then drop enable_a and change address_a to 9 -> OutA stays 0x0E. Repeat on B.
- Write disable: with enable_w=0, drive In=0xFFFFFFFF at reg 3 -> reg 3 still reads 0x06.
- Collision: reg 4 holds 0x08. Write 0x55 to reg 4 while reading reg 4 on both ports -> OutA=OutB=0x55 with REGFILE_WR_BYPASS_EN defined, 0x08 without it. The next read returns 0x55 in both builds.

Source files
------------

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// General-purpose register file with one synchronous write port and two
// independent, registered read ports. It sits between instruction decode
// and the ALU. On each clock edge it supplies two operands and accepts one
// write-back.
//
// Parameters
//   DATA_WIDTH : width of each register and of In / OutA / OutB
//   ADDR_WIDTH : address width
//   DEPTH      : number of registers; must equal 2**ADDR_WIDTH
//
// Ports
//   clk       : system clock; all state updates on the rising edge
//   rst       : asynchronous, active-high reset; clears array and outputs
//   In        : write data
//   address_w : write address
//   enable_w  : write enable
//   address_a : read port A address
//   enable_a  : read port A enable; OutA holds while low
//   address_b : read port B address
//   enable_b  : read port B enable; OutB holds while low
//   OutA      : registered read data, port A (1-cycle latency)
//   OutB      : registered read data, port B (1-cycle latency)
//
// Configuration
//   REGFILE_WR_BYPASS_EN : when defined, a read that hits the address being
//                          written at the same edge returns the new data (In).
//                          When undefined (default), the read returns the old
//                          contents, and the new value is visible one edge later.
//
// Entry 0 is an ordinary register. There is no hardwired zero.
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] In,
  input  logic [ADDR_WIDTH-1:0] address_w,
  input  logic                  enable_w,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  enable_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  enable_b,
  output logic [DATA_WIDTH-1:0] OutA,
  output logic [DATA_WIDTH-1:0] OutB
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Data that each port captures at the next edge if it is enabled.
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;

  // -------------------------------------------------------------------------
  // Write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every entry must clear asynchronously, so the array is built
      // from resettable flops rather than inferred as a RAM macro, which has
      // no reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enable_w) begin
      // NOTE: use non-blocking assignments for all state. The read ports
      // then sample the pre-edge contents, which gives the "old data"
      // collision behaviour without any extra logic.
      mem[address_w] <= In;
    end
  end

  // -------------------------------------------------------------------------
  // Read data selection (array lookup, plus optional write forwarding)
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign defaults first so that no path leaves a signal
    // unassigned. An unassigned path would infer a latch.
    rd_data_a = mem[address_a];
    rd_data_b = mem[address_b];
`ifdef REGFILE_WR_BYPASS_EN
    // Forward the write data so a same-edge read sees the new value.
    if (enable_w && (address_w == address_a)) begin
      rd_data_a = In;
    end
    if (enable_w && (address_w == address_b)) begin
      rd_data_b = In;
    end
`else
    // No forwarding. A same-edge read returns the old contents, which is
    // exactly what the pre-edge array already provides.
`endif
  end

  // -------------------------------------------------------------------------
  // Registered read ports. Each holds its value while its enable is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutA <= '0;
    end else if (enable_a) begin
      OutA <= rd_data_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutB <= '0;
    end else if (enable_b) begin
      OutB <= rd_data_b;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file. A behavioural model of the array
// runs alongside the DUT. Each driven cycle pushes the expected OutA and OutB
// onto two scoreboard queues. The scenario tasks pop those entries after the
// edge and compare them against the DUT outputs.
// Build with +define+REGFILE_WR_BYPASS_EN to check the forwarding variant.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [AW-1:0] address_w, address_a, address_b;
  logic          enable_w, enable_a, enable_b;
  logic [DW-1:0] out_a, out_b;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .In        (in_data),
    .address_w (address_w),
    .enable_w  (enable_w),
    .address_a (address_a),
    .enable_a  (enable_a),
    .address_b (address_b),
    .enable_b  (enable_b),
    .OutA      (out_a),
    .OutB      (out_b)
  );

  always #5 clk = ~clk;

  // Model and scoreboard
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_a, last_b;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  int total = 0;
  int bad   = 0;

  // Drives one cycle of stimulus, queues the expected outputs, then advances
  // past the edge to a point where the outputs can be sampled.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ea, input logic [AW-1:0] aa,
                      input logic eb, input logic [AW-1:0] ab);
    enable_w = we; address_w = wa; in_data = wd;
    enable_a = ea; address_a = aa;
    enable_b = eb; address_b = ab;
    if (ea) last_a = (BYPASS && we && (wa == aa)) ? wd : model[aa];
    if (eb) last_b = (BYPASS && we && (wa == ab)) ? wd : model[ab];
    q_a.push_back(last_a);
    q_b.push_back(last_b);
    if (we) model[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_a = '0;
    last_b = '0;
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_reset();
    logic [DW-1:0] ea, eb;
    total++;
    if (out_a !== '0) begin bad++; $display("FAIL reset_init_a got=%h exp=0", out_a); end
    total++;
    if (out_b !== '0) begin bad++; $display("FAIL reset_init_b got=%h exp=0", out_b); end
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    void'(q_a.pop_front()); void'(q_b.pop_front());
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL pre_reset_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL pre_reset_b got=%h exp=%h", out_b, eb); end
    // Assert reset between edges. The outputs must clear without a clock.
    enable_a = 1'b0; enable_b = 1'b0; enable_w = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_a !== '0) begin bad++; $display("FAIL async_reset_a got=%h exp=0", out_a); end
    total++;
    if (out_b !== '0) begin bad++; $display("FAIL async_reset_b got=%h exp=0", out_b); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL post_reset_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL post_reset_b got=%h exp=%h", out_b, eb); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] ea, eb;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, AW'(i), DW'(2 * i), 1'b0, 5'd0, 1'b0, 5'd0);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL fill_hold_a i=%0d got=%h exp=%h", i, out_a, ea); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, AW'(i), 1'b0, 5'd0);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL sweep_a addr=%0d got=%h exp=%h", i, out_a, ea); end
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL sweep_a_hold_b addr=%0d got=%h exp=%h", i, out_b, eb); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, AW'(i));
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL sweep_b addr=%0d got=%h exp=%h", i, out_b, eb); end
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL sweep_b_hold_a addr=%0d got=%h exp=%h", i, out_a, ea); end
    end
  endtask

  task automatic test_dual_read();
    logic [DW-1:0] ea, eb;
    logic [AW-1:0] aa, ab;
    for (int i = 0; i < 24; i++) begin
      aa = AW'($urandom_range(0, 15));
      ab = AW'($urandom_range(16, 31));
      step(1'b0, 5'd0, 32'h0, 1'b1, aa, 1'b1, ab);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL dual_a addr=%0d got=%h exp=%h", aa, out_a, ea); end
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL dual_b addr=%0d got=%h exp=%h", ab, out_b, eb); end
    end
  endtask

  task automatic test_enable_hold();
    logic [DW-1:0] ea, eb;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL hold_load_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL hold_load_b got=%h exp=%h", out_b, eb); end
    // Port A disabled and moved to reg 9; port B keeps reading 7.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 5'd7);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL hold_a got=%h exp=%h", out_a, ea); end
    end
    // Port B disabled and moved to reg 9; port A keeps reading 7.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd9);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL hold_b got=%h exp=%h", out_b, eb); end
    end
  endtask

  task automatic test_write_disable();
    logic [DW-1:0] ea, eb;
    step(1'b0, 5'd3, 32'hFFFFFFFF, 1'b1, 5'd3, 1'b1, 5'd3);
    void'(q_a.pop_front()); void'(q_b.pop_front());
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL wr_disable_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL wr_disable_b got=%h exp=%h", out_b, eb); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] ea, eb;
    step(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 1'b1, 5'd4);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL collide_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL collide_b got=%h exp=%h", out_b, eb); end
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    total++;
    if (out_a !== ea) begin bad++; $display("FAIL collide_next_a got=%h exp=%h", out_a, ea); end
    total++;
    if (out_b !== eb) begin bad++; $display("FAIL collide_next_b got=%h exp=%h", out_b, eb); end
  endtask

  // Random write followed by an immediate read of the same entry, with
  // unrelated reads and writes in flight on the other port.
  task automatic test_back_to_back();
    logic [DW-1:0] ea, eb, wd;
    logic [AW-1:0] wa, ab;
    for (int i = 0; i < 20; i++) begin
      wa = AW'($urandom_range(0, DEPTH - 1));
      ab = AW'($urandom_range(0, DEPTH - 1));
      wd = DW'($urandom);
      step(1'b1, wa, wd, 1'b0, 5'd0, 1'b1, ab);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL b2b_wr_b addr=%0d got=%h exp=%h", ab, out_b, eb); end
      step(1'b1, ab, ~wd, 1'b1, wa, 1'b1, wa);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      total++;
      if (out_a !== ea) begin bad++; $display("FAIL b2b_rd_a addr=%0d got=%h exp=%h", wa, out_a, ea); end
      total++;
      if (out_b !== eb) begin bad++; $display("FAIL b2b_rd_b addr=%0d got=%h exp=%h", wa, out_b, eb); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; address_w = '0; address_a = '0; address_b = '0;
    enable_w = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    model_clear();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_dual_read();
    test_enable_hold();
    test_write_disable();
    test_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
